// File: rtl/shift_pipe_pkg.sv
// Shared shifter definitions: operation encodings and per-stage control bundle.
// SHIFT_PIPE_ROTATE_EN selects whether mode 11 rotates or is flagged illegal.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  // Control fields that travel alongside the data through every stage.
  typedef struct packed {
    logic        vld;
    shift_mode_e mode;
    logic        illegal;
  } stage_ctl_t;

endpackage

// File: rtl/shift_pipe_stage.sv
// One barrel-shifter level: conditionally shifts by SHIFT_BY, then registers.
// Latency 1 cycle; holds all registers while stall is high.
// Rotate wrap logic exists only with SHIFT_PIPE_ROTATE_EN defined.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BY   = 16,
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  stage_ctl_t             ctl_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [SHAMT_WIDTH-1:0] shamt_in,
  output stage_ctl_t             ctl_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [SHAMT_WIDTH-1:0] shamt_out
);

  localparam int SEL_BIT = $clog2(SHIFT_BY);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] data_next;

  // Earlier right-arithmetic levels preserve the sign, so the current MSB
  // is always the original operand MSB.
  always_comb begin
    shifted = data_in;
    unique case (ctl_in.mode)
      MODE_SLL: shifted = data_in << SHIFT_BY;
      MODE_SRL: shifted = data_in >> SHIFT_BY;
      MODE_SRA: shifted = $signed(data_in) >>> SHIFT_BY;
      MODE_ROR: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        shifted = {data_in[SHIFT_BY-1:0], data_in[DATA_WIDTH-1:SHIFT_BY]};
`else
        shifted = '0;
`endif
      end
    endcase
    data_next = shamt_in[SEL_BIT] ? shifted : data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_out   <= '0;
      data_out  <= '0;
      shamt_out <= '0;
    end else if (!stall) begin
      ctl_out   <= ctl_in;
      data_out  <= data_next;
      shamt_out <= shamt_in;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR shifter, one register stage per shamt bit (MSB first).
// Latency SHAMT_WIDTH cycles, 1 op/cycle; global stall when out_valid && !out_ready.
// SHIFT_PIPE_ROTATE_EN enables ROR; otherwise mode 11 yields 0 with out_illegal.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_illegal
);

  stage_ctl_t             ctl   [SHAMT_WIDTH+1];
  logic [DATA_WIDTH-1:0]  data  [SHAMT_WIDTH+1];
  logic [SHAMT_WIDTH-1:0] shamt [SHAMT_WIDTH+1];
  logic                   stall;
  logic                   in_illegal;
  logic                   unused_tail;

`ifdef SHIFT_PIPE_ROTATE_EN
  assign in_illegal = 1'b0;
`else
  assign in_illegal = (in_mode == MODE_ROR);
`endif

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // An unsupported op enters as zero so every level just passes zero along.
  assign ctl[0].vld     = in_valid;
  assign ctl[0].mode    = shift_mode_e'(in_mode);
  assign ctl[0].illegal = in_illegal;
  assign data[0]        = in_illegal ? '0 : in_data;
  assign shamt[0]       = in_shamt;

  for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
    shift_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_BY   (1 << (SHAMT_WIDTH - 1 - k))
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .ctl_in    (ctl[k]),
      .data_in   (data[k]),
      .shamt_in  (shamt[k]),
      .ctl_out   (ctl[k+1]),
      .data_out  (data[k+1]),
      .shamt_out (shamt[k+1])
    );
  end

  assign out_valid   = ctl[SHAMT_WIDTH].vld;
  assign out_data    = data[SHAMT_WIDTH];
  assign out_illegal = ctl[SHAMT_WIDTH].illegal;

  assign unused_tail = ^{ctl[SHAMT_WIDTH].mode, shamt[SHAMT_WIDTH]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed + randomized bench for shift_pipe against a queue-based reference model.
module tb_shift_pipe;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_illegal;

  always #5 clk = ~clk;

  shift_pipe #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          ill;
    int            t;
    int            s;
  } exp_t;

  exp_t q[$];
  int   n_assert   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   stalls     = 0;
  int   ready_low  = 0;

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] a, input int s,
                                               input logic [1:0] m);
    logic [2*DW-1:0] w;
    case (m)
      2'd0: return a << s;
      2'd1: return a >> s;
      2'd2: begin
        w = {{DW{a[DW-1]}}, a} >> s;
        return w[DW-1:0];
      end
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        w = {a, a} >> s;
        return w[DW-1:0];
`else
        return '0;
`endif
      end
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [1:0] m);
`ifdef SHIFT_PIPE_ROTATE_EN
    return 1'b0;
`else
    return m == 2'd3;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, account handshakes, advance.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [SW-1:0] s,
                      input logic [1:0] m, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = iv;
    in_data   = d;
    in_shamt  = s;
    in_mode   = m;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !(out_valid && !ordy));
    if (!in_ready) ready_low++;
    if (out_valid && !ordy) stalls++;
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check("out_valid_with_empty_model", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("out_data", out_data, e.d);
        check("out_illegal", out_illegal, e.ill);
        check("latency", cyc, e.t + SW + (stalls - e.s));
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      e.d   = ref_result(d, int'(s), m);
      e.ill = ref_illegal(m);
      e.t   = cyc;
      e.s   = stalls;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Single operand whose expected result is a hand-written literal.
  task automatic send_lit(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [1:0] m,
                          input logic [DW-1:0] lit_d, input logic lit_ill);
    logic acc;
    exp_t e;
    step(1'b1, d, s, m, 1'b1, acc);
    check("direct_accept", acc, 1'b1);
    if (acc) begin
      e     = q.pop_back();
      e.d   = lit_d;
      e.ill = lit_ill;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, '0, '0, 2'd0, 1'b1, acc);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic          acc;
    logic          have;
    logic [DW-1:0] hd;
    logic [SW-1:0] hs;
    logic [1:0]    hm;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 0);
    check("reset_out_illegal", out_illegal, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner values
    send_lit(32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001, 1'b0);
    send_lit(32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000, 1'b0);
    send_lit(32'h7FFF_FFFF, 5'd4,  2'd2, 32'h07FF_FFFF, 1'b0);
    send_lit(32'h0000_0001, 5'd16, 2'd0, 32'h0001_0000, 1'b0);
    send_lit(32'hDEAD_BEEF, 5'd0,  2'd0, 32'hDEAD_BEEF, 1'b0);
    send_lit(32'hDEAD_BEEF, 5'd0,  2'd1, 32'hDEAD_BEEF, 1'b0);
    send_lit(32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
    send_lit(32'hDEAD_BEEF, 5'd0,  2'd3, 32'hDEAD_BEEF, 1'b0);
    send_lit(32'h0000_0001, 5'd1,  2'd3, 32'h8000_0000, 1'b0);
`else
    send_lit(32'h0000_0001, 5'd1,  2'd3, 32'h0000_0000, 1'b1);
`endif
    send_lit(32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1'b0);
    drain();

    // Five back-to-back operands, consumer stalls 3 cycles on the first result
    ready_low = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, SW'($urandom), 2'($urandom_range(0, 2)), 1'b1, acc);
      check("b2b_accept", acc, 1'b1);
    end
    hd = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, hd, 5'd7, 2'd2, 1'b0, acc);
      check("stall_reject", acc, 1'b0);
    end
    step(1'b1, hd, 5'd7, 2'd2, 1'b1, acc);
    check("represent_accept", acc, 1'b1);
    drain();
    check("ready_low_cycles", ready_low, 3);

    // Reset with three operands in flight
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, SW'($urandom), 2'd1, 1'b1, acc);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("post_reset_no_out_valid", out_valid, 1'b0);
      check("post_reset_in_ready", in_ready, 1'b1);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    // Randomized traffic with producer holding an operand until accepted
    have = 1'b0;
    hd   = '0;
    hs   = '0;
    hm   = 2'd0;
    for (int i = 0; i < 600; i++) begin
      if (!have && $urandom_range(0, 99) < 70) begin
        have = 1'b1;
        hd   = $urandom;
        case ($urandom_range(0, 3))
          0:       hs = '0;
          1:       hs = 5'd31;
          default: hs = SW'($urandom);
        endcase
        hm = 2'($urandom);
      end
      step(have, hd, hs, hm, $urandom_range(0, 99) < 75, acc);
      if (acc) have = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
